// File: rtl/timer_sched_pkg.sv
// Shared types for timer_sched: FSM state encoding and the counter start-value helper.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_W = 32;

  // Two's complement of the duration; an up-counter loaded with this hits all-ones after dur-1 increments.
  function automatic logic [MAX_W-1:0] start_value(input logic [MAX_W-1:0] dur);
    return ~dur + 1'b1;
  endfunction

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from rr_ptr+1, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            any,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  always_comb begin
    logic [IW-1:0] cand;
    cand = '0;
    any  = 1'b0;
    gnt  = '0;
    idx  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IW'((int'(rr_ptr) + off) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Time-shares one external N-bit up-counter among NREQ requesters, round-robin, with a done pulse per interval.
// Optional abort on owner req drop is enabled by defining TIMER_SCHED_ABORT_EN.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*N-1:0] dur,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            cnt_load,
  output logic            cnt_en,
  output logic [N-1:0]    cnt_load_data,
  input  logic [N-1:0]    cnt_count
);

  localparam int IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    dur_q, dur_d;

  logic            pick_any;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [N-1:0]    dur_pick;
  logic [NREQ-1:0] owner_hot;
  logic [MAX_W-1:0] start_full;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  // One-hot mux of the winner's duration field.
  always_comb begin
    dur_pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) dur_pick = dur_pick | dur[i*N +: N];
    end
  end

  assign owner_hot  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  assign start_full = start_value(MAX_W'(dur_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      dur_q    <= dur_d;
    end
  end

  // Outputs depend only on registered state, owner and captured duration.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    dur_d         = dur_q;
    gnt           = '0;
    done          = '0;
    busy          = (state_q != IDLE);
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    cnt_load_data = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          dur_d   = dur_pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        gnt           = owner_hot;
        cnt_load      = 1'b1;
        cnt_load_data = start_full[N-1:0];
        state_d       = RUN;
`ifdef TIMER_SCHED_ABORT_EN
        if (!req[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
        end
`endif
      end
      RUN: begin
        gnt    = owner_hot;
        cnt_en = 1'b1;
        if (cnt_count == {N{1'b1}}) state_d = DONE;
`ifdef TIMER_SCHED_ABORT_EN
        if (!req[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
        end
`endif
      end
      DONE: begin
        gnt      = owner_hot;
        done     = owner_hot;
        rr_ptr_d = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural model of the shared loadable counter.
module tb_timer_sched;

  localparam int N    = 8;
  localparam int NREQ = 4;

  logic            clk;
  logic            reset_n;
  logic [NREQ-1:0] req;
  logic [NREQ*N-1:0] dur;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            busy;
  logic            cnt_load;
  logic            cnt_en;
  logic [N-1:0]    cnt_load_data;
  logic [N-1:0]    cnt = '0;

  int total = 0;
  int bad   = 0;

  timer_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .dur           (dur),
    .gnt           (gnt),
    .done          (done),
    .busy          (busy),
    .cnt_load      (cnt_load),
    .cnt_en        (cnt_en),
    .cnt_load_data (cnt_load_data),
    .cnt_count     (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External counter: synchronous load beats increment; not reset by reset_n.
  always @(posedge clk) begin
    if (cnt_load)    cnt <= cnt_load_data;
    else if (cnt_en) cnt <= cnt + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the LOAD-cycle negedge; returns RUN cycles seen, done vector, cycles until done.
  task automatic run_until_done(output int en_n, output logic [NREQ-1:0] dn, output int cyc);
    en_n = 0;
    dn   = '0;
    cyc  = 0;
    while (dn == '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cnt_en) en_n++;
      dn = done;
    end
  endtask

  // Issue one request from IDLE, check load value, RUN length and done owner, return to IDLE.
  task automatic one_shot(input string tag, input logic [NREQ-1:0] r, input logic [NREQ-1:0] exp_g,
                          input logic [7:0] exp_data, input int exp_en);
    int en_n, cyc;
    logic [NREQ-1:0] dn;
    req = r;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    chk({tag, "_load_data"}, 32'(cnt_load_data), 32'(exp_data));
    run_until_done(en_n, dn, cyc);
    chk({tag, "_run_cycles"}, 32'(en_n), 32'(exp_en));
    chk({tag, "_done"}, 32'(dn), 32'(exp_g));
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    int en_n, en2, cyc, w;
    logic [NREQ-1:0] dn, dsum;
    logic [NREQ-1:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset_n = 1'b0;
    req     = '0;
    dur     = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_load", 32'(cnt_load), 32'h0);
    chk("rst_en", 32'(cnt_en), 32'h0);
    chk("rst_load_data", 32'(cnt_load_data), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fairness: all four held, dur=2 each, expected grant order 0,1,2,3,0.
    dur = 32'h02020202;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!cnt_load && w < 10);
      chk("rr_gnt", 32'(gnt), 32'(exp_g[k]));
      run_until_done(en_n, dn, cyc);
      chk("rr_done", 32'(dn), 32'(exp_g[k]));
      chk("rr_run_cycles", 32'(en_n), 32'd2);
    end
    req = '0;
    @(negedge clk);

    // Single request, dur=5.
    dur = '0;
    dur[7:0] = 8'd5;
    req = 4'b0001;
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_load", 32'(cnt_load), 32'h1);
    chk("single_en_in_load", 32'(cnt_en), 32'h0);
    chk("single_load_data", 32'(cnt_load_data), 32'hFB);
    chk("single_busy", 32'(busy), 32'h1);
    run_until_done(en_n, dn, cyc);
    chk("single_run_cycles", 32'(en_n), 32'd5);
    chk("single_done", 32'(dn), 32'h1);
    chk("single_done_latency", 32'(cyc), 32'd6);
    req = '0;
    @(negedge clk);
    chk("single_done_pulse_width", 32'(done), 32'h0);
    chk("single_busy_after", 32'(busy), 32'h0);
    chk("single_gnt_after", 32'(gnt), 32'h0);

    // Boundary durations.
    dur[7:0] = 8'd1;
    one_shot("dur1", 4'b0001, 4'b0001, 8'hFF, 1);
    dur[7:0] = 8'd0;
    one_shot("dur0", 4'b0001, 4'b0001, 8'h00, 256);

    // Duration change after capture is ignored.
    dur[15:8] = 8'd4;
    req = 4'b0010;
    @(negedge clk);
    chk("cap_load_data", 32'(cnt_load_data), 32'hFC);
    dur[15:8] = 8'd9;
    run_until_done(en_n, dn, cyc);
    chk("cap_run_cycles", 32'(en_n), 32'd4);
    chk("cap_done", 32'(dn), 32'h2);
    req = '0;
    @(negedge clk);

    // Owner drops req in the 4th RUN cycle of a 10-cycle interval.
    dur[23:16] = 8'd10;
    req = 4'b0100;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h4);
    en_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (cnt_en) en_n++;
    end
    chk("abort_pre_en", 32'(en_n), 32'd4);
    req = '0;
`ifdef TIMER_SCHED_ABORT_EN
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_en", 32'(cnt_en), 32'h0);
    dsum = '0;
    repeat (12) begin
      @(negedge clk);
      dsum = dsum | done;
    end
    chk("abort_no_done", 32'(dsum), 32'h0);
`else
    run_until_done(en2, dn, cyc);
    chk("noabort_run_cycles", 32'(en_n + en2), 32'd10);
    chk("noabort_done", 32'(dn), 32'h4);
    @(negedge clk);
`endif

    // Reset after 3 of 10 RUN cycles; priority returns to requester 0.
    dur[7:0] = 8'd10;
    req = 4'b0001;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pre_rst_en", 32'(cnt_en), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_load", 32'(cnt_load), 32'h0);
    chk("midrst_en", 32'(cnt_en), 32'h0);
    chk("midrst_load_data", 32'(cnt_load_data), 32'h0);
    dsum = '0;
    repeat (3) begin
      @(negedge clk);
      dsum = dsum | done;
    end
    chk("midrst_no_done", 32'(dsum), 32'h0);
    dur = 32'h03030303;
    req = 4'b1111;
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_gnt", 32'(gnt), 32'h1);
    chk("postrst_load_data", 32'(cnt_load_data), 32'hFD);
    run_until_done(en_n, dn, cyc);
    chk("postrst_done", 32'(dn), 32'h1);
    req = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
